// File: rtl/multdiv_unit_if.sv
// Bus interface for multdiv_unit.
//   data_operandA/B  : signed operands, sampled on the start edge
//   ctrl_MULT/DIV    : one-cycle start pulses (MULT wins when both are high)
//   data_result      : product low word or quotient, held until next completion
//   data_exception   : overflow / divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY   : one-cycle completion pulse
//   busy             : high while an operation is in flight (pipeline stall)
//   dbg_state        : current FSM state, for checkers and waveform debug
// Handshake: a start pulse is accepted only when busy is low; exactly one
// data_resultRDY pulse follows each accepted start unless reset intervenes.
// The master modport is the requesting side, the slave modport is the unit.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy, dbg_state
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy, dbg_state
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / divide unit.
// Multiply: shift-add on operand magnitudes, sign applied at completion;
// result is the low WIDTH bits of the signed product, exception on overflow.
// Divide: restoring division on magnitudes, quotient truncated toward zero;
// exception (result 0) on divide-by-zero or most-negative / -1.
// One iteration per cycle for WIDTH cycles, then one finalize cycle, so the
// completion pulse arrives WIDTH+1 edges after the start edge.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : multdiv_unit_if slave modport (operands, starts, results, busy)
// Optional feature: define MULTDIV_EARLY_DIV0_EN to finish a divide by zero
// one edge after the start edge instead of running all iterations.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  multdiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // The counter runs 0..WIDTH-1 across the iterations; once it reaches WIDTH
  // the next edge is the finalize edge (sign fix-up, exception, RDY pulse).
  logic [CW-1:0]      cnt_q;
  // Multiply: {partial product high, multiplier shifting out at bit 0}.
  // Divide:   {remainder, dividend shifting in quotient bits at bit 0}.
  logic [2*WIDTH-1:0] acc_q;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;

  logic               iter_done;
  logic               div0;
  logic               finish;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mult_next;
  logic [WIDTH-1:0]   shifted_rem;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH:0]     prod_top;
  logic               mult_exc;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   quo_signed;
  logic               div_exc;

  assign a_neg = bus.data_operandA[WIDTH-1];
  assign b_neg = bus.data_operandB[WIDTH-1];
  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = a_neg ? -bus.data_operandA : bus.data_operandA;
  assign b_mag = b_neg ? -bus.data_operandB : bus.data_operandB;

  assign iter_done = (cnt_q == CW'(WIDTH));
  assign div0      = (opnd_q == '0);

  // Multiply step: conditionally add the multiplicand into the high half,
  // then shift the whole accumulator right by one.
  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mult_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide step: the remainder is always below the divisor (<= 2^(WIDTH-1)),
  // so its top bit is zero and the left shift fits in WIDTH bits.
  assign shifted_rem = acc_q[2*WIDTH-2:WIDTH-1];
  assign diff        = {1'b0, shifted_rem} - {1'b0, opnd_q};
  assign div_next    = diff[WIDTH] ? {shifted_rem, acc_q[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Finalize: apply sign and detect results that do not fit WIDTH signed bits.
  assign prod_signed = neg_q ? -acc_q : acc_q;
  assign prod_top    = prod_signed[2*WIDTH-1:WIDTH-1];
  assign mult_exc    = ~((&prod_top) | ~(|prod_top));
  assign quo_mag     = acc_q[WIDTH-1:0];
  assign quo_signed  = neg_q ? -quo_mag : quo_mag;
  // A positive quotient of 2^(WIDTH-1) only arises from most-negative / -1.
  assign div_exc     = div0 | (~neg_q & quo_mag[WIDTH-1]);

  always_comb begin
    finish = 1'b0;
    case (state_q)
      MULT:    finish = iter_done;
`ifdef MULTDIV_EARLY_DIV0_EN
      DIV:     finish = iter_done | div0;
`else
      DIV:     finish = iter_done;
`endif
      default: finish = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.ctrl_MULT)     state_d = MULT;
        else if (bus.ctrl_DIV) state_d = DIV;
      end
      MULT, DIV: begin
        if (finish) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.ctrl_MULT) begin
            opnd_q <= a_mag;
            acc_q  <= {{WIDTH{1'b0}}, b_mag};
            neg_q  <= a_neg ^ b_neg;
            cnt_q  <= '0;
          end else if (bus.ctrl_DIV) begin
            opnd_q <= b_mag;
            acc_q  <= {{WIDTH{1'b0}}, a_mag};
            neg_q  <= a_neg ^ b_neg;
            cnt_q  <= '0;
          end
        end
        MULT: begin
          if (finish) begin
            result_q <= prod_signed[WIDTH-1:0];
            exc_q    <= mult_exc;
            rdy_q    <= 1'b1;
          end else begin
            acc_q <= mult_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DIV: begin
          if (finish) begin
            result_q <= div_exc ? '0 : quo_signed;
            exc_q    <= div_exc;
            rdy_q    <= 1'b1;
          end else begin
            acc_q <= div_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: rdy_q <= 1'b0;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q == MULT) || (state_q == DIV);
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases, a mid-operation
// reset, then randomized operations, all checked against an arithmetic model.
module tb_multdiv_unit;

  localparam int W = 32;

  logic clock;
  logic reset;

  multdiv_unit_if #(.WIDTH(W)) bus ();

  multdiv_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [W:0]   exp_q[$];   // {exception, result}
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_res = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic logic [W:0] model(input bit is_mult, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    longint sa, sb, p, q, lo, hi;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = -(longint'(1) <<< (W - 1));
    hi = (longint'(1) <<< (W - 1)) - 1;
    if (is_mult) begin
      p  = sa * sb;
      pu = p;
      return {(p < lo) || (p > hi), pu[W-1:0]};
    end
    if (sb == 0) return {1'b1, {W{1'b0}}};
    if (sa == lo && sb == -1) return {1'b1, {W{1'b0}}};
    q  = sa / sb;
    pu = q;
    return {1'b0, pu[W-1:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input bit m, input bit d, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag);
    logic [W:0] exp;
    int exp_lat;
    int lat;
    exp = model(m, a, b);
    exp_q.push_back(exp);
    exp_lat = W + 1;
`ifdef MULTDIV_EARLY_DIV0_EN
    if (!m && b == '0) exp_lat = 1;
`endif
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    check({tag, " rdy_after_start"}, bus.data_resultRDY, 0);
    check({tag, " busy_after_start"}, bus.busy, 1);
    check({tag, " result_held"}, bus.data_result, prev_res);
    lat = 0;
    while (bus.data_resultRDY !== 1'b1 && lat < 100) begin
      if (lat == 5 && exp_lat > 8) begin
        bus.ctrl_MULT = 1'b1;
        bus.ctrl_DIV  = 1'b1;
      end else begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
      end
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    exp = exp_q.pop_front();
    check({tag, " result"}, bus.data_result, exp[W-1:0]);
    check({tag, " exception"}, bus.data_exception, exp[W]);
    check({tag, " busy_done"}, bus.busy, 0);
    prev_res = exp[W-1:0];
  endtask

  function automatic logic [W-1:0] rand_opnd();
    int sel;
    logic [W-1:0] v;
    sel = $urandom_range(0, 5);
    case (sel)
      0: v = W'($signed($urandom_range(0, 40)) - 20);
      1: v = '0;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = W'($signed($urandom_range(0, 65535)) - 32768);
      4: v = '1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int rdy_seen;
    int op;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    reset             = 1'b0;

    repeat (2) @(negedge clock);
    check("reset result", bus.data_result, 0);
    check("reset exception", bus.data_exception, 0);
    check("reset rdy", bus.data_resultRDY, 0);
    check("reset busy", bus.busy, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Directed cases, issued back to back from DONE.
    run_op(1, 0, 32'd6, 32'd7, "mult_6x7");
    run_op(1, 0, -32'sd5, 32'd3, "mult_m5x3");
    run_op(1, 0, 32'h0001_0000, 32'h0001_0000, "mult_ovf");
    run_op(1, 1, 32'd12, -32'sd4, "both_ctrl_mult_wins");
    run_op(0, 1, -32'sd100, 32'd7, "div_m100_7");
    run_op(0, 1, 32'd100, 32'd7, "div_100_7");
    run_op(0, 1, 32'd5, 32'd0, "div_by_zero");
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(0, 1, 32'h8000_0000, 32'd1, "div_min_1");
    run_op(0, 1, -32'sd7, -32'sd2, "div_m7_m2");
    run_op(0, 1, -32'sd3, 32'd7, "div_small_neg");
    run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_m1");
    run_op(1, 0, 32'h8000_0000, 32'd1, "mult_min_1");

    // Idle in DONE: no further RDY, result held.
    repeat (3) begin
      @(negedge clock);
      check("done_idle rdy", bus.data_resultRDY, 0);
      check("done_idle result", bus.data_result, prev_res);
    end

    // Mid-operation reset.
    bus.data_operandA = 32'd20;
    bus.data_operandB = 32'd4;
    bus.ctrl_DIV      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    repeat (10) @(negedge clock);
    bus.data_operandA = 32'd2;
    bus.data_operandB = 32'd3;
    bus.ctrl_MULT     = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    check("midop extra start ignored busy", bus.busy, 1);
    check("midop result held", bus.data_result, prev_res);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    check("async reset result", bus.data_result, 0);
    check("async reset exception", bus.data_exception, 0);
    check("async reset rdy", bus.data_resultRDY, 0);
    check("async reset busy", bus.busy, 0);
    rdy_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) rdy_seen++;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) rdy_seen++;
    end
    check("abandoned op no rdy", rdy_seen, 0);
    check("abandoned op idle busy", bus.busy, 0);
    prev_res = '0;
    run_op(1, 0, 32'd2, 32'd3, "mult_after_reset");

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      case (op)
        0:       run_op(1, 0, rand_opnd(), rand_opnd(), "rand_mult");
        1:       run_op(0, 1, rand_opnd(), rand_opnd(), "rand_div");
        default: run_op(1, 1, rand_opnd(), rand_opnd(), "rand_both");
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
